// File: rtl/rtos_nios2_debug_ocimem.sv
// OCI debug memory for the RTOS Nios II core: a single-port 2^AW x 32 RAM shared
// between the JTAG debug path (strobe driven) and a CPU slave port with waitrequest.
module rtos_nios2_debug_ocimem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_writedata,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] JADDR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] jaddr;
    logic [AW-1:0] jaddr_next;

    logic [31:0]   mem [0:DEPTH-1];
    logic [31:0]   ram_q;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          ram_re;

    logic          strobe_any;
    logic          jtag_take;
    logic          clear_ready;
    logic          clear_error;
    logic          cpu_req;
    logic          unused_jdo;

    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_take  = strobe_any & (state != JRD);
    assign cpu_req    = cpu_read | cpu_write;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // The RAM port is free in IDLE and CRD (CRD only consumes last cycle's read data),
    // so JTAG may claim it there; in JRD every strobe is dropped.
    always_comb begin
        state_next  = IDLE;
        jaddr_next  = jaddr;
        ram_addr    = jaddr;
        ram_wdata   = jdo[34:3];
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        clear_ready = 1'b0;
        clear_error = 1'b0;
        if (jtag_take) begin
            if (take_action_ocimem_a) begin
                jaddr_next  = jdo[17 +: AW];
                clear_ready = 1'b1;
                clear_error = jdo[35];
                if (jdo[34]) begin
                    ram_addr   = jdo[17 +: AW];
                    ram_re     = 1'b1;
                    state_next = JRD;
                end
            end else if (take_action_ocimem_b) begin
                ram_we     = 1'b1;
                jaddr_next = jaddr + JADDR_ONE;
            end else begin
                clear_ready = 1'b1;
                ram_re      = 1'b1;
                state_next  = JRD;
            end
        end else if (state == JRD) begin
            jaddr_next = jaddr + JADDR_ONE;
        end else if (state == IDLE && cpu_read) begin
            ram_addr   = cpu_address;
            ram_re     = 1'b1;
            state_next = CRD;
        end else if (state == IDLE && cpu_write) begin
            ram_addr  = cpu_address;
            ram_wdata = cpu_writedata;
            ram_we    = 1'b1;
        end
    end

    // CPU handshake: a request held high completes in the first cycle waitrequest is low.
    // A write completes in IDLE with no strobe; a read completes in CRD even if JTAG
    // takes the port in that same cycle.
    always_comb begin
        cpu_waitrequest = 1'b0;
        unique case (state)
            IDLE:    cpu_waitrequest = cpu_req & (strobe_any | cpu_read);
            CRD:     cpu_waitrequest = cpu_req & ~cpu_read;
            default: cpu_waitrequest = cpu_req;
        endcase
    end

    assign cpu_readdata = (state == CRD) ? ram_q : 32'h0;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            jaddr         <= '0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state <= state_next;
            jaddr <= jaddr_next;
            if (state == JRD) begin
                MonDReg       <= ram_q;
                monitor_ready <= 1'b1;
            end else if (clear_ready) begin
                monitor_ready <= 1'b0;
            end
            if (state == JRD && strobe_any) begin
                monitor_error <= 1'b1;
            end else if (clear_error) begin
                monitor_error <= 1'b0;
            end
        end
    end

endmodule
